enemy_spawn_sched: RTL and testbench

//  Frame-paced scheduler that decides when, where and which enemy type spawns.

---
 rtl/enemy_spawn_sched.sv | 171 +++++++++++++++++
 tb/tb_enemy_spawn_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_sched.sv
`default_nettype none
// ============================================================================
// Module  : enemy_spawn_sched
// Brief   : Frame-paced enemy spawn scheduler with kill-driven difficulty.
// Revision: 1.0 - initial release
// ============================================================================
module enemy_spawn_sched #(
    parameter int RAND_WIDTH      = 16,
    parameter int X_MAX           = 590,
    parameter int BASE_INTERVAL   = 60,
    parameter int INTERVAL_STEP   = 4,
    parameter int MIN_INTERVAL    = 15,
    parameter int KILLS_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int ACK_TIMEOUT     = 8
) (
    input  logic                  clk_run,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [RAND_WIDTH-1:0] rand_i,
    input  logic                  v_sync_i,
    input  logic                  crash_enemy_bullet_i,
    input  logic                  crash_me_enemy_i,
    input  logic                  spawn_ack1_i,
    input  logic                  spawn_ack2_i,
    output logic                  spawn_req_o,
    output logic                  spawn_type_o,
    output logic [9:0]            spawn_x_o,
    output logic [3:0]            level_o,
    output logic [15:0]           kill_cnt_o,
    output logic                  halted_o
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_WAIT = 3'd1;
    localparam logic [2:0] c_PICK = 3'd2;
    localparam logic [2:0] c_REQ  = 3'd3;
    localparam logic [2:0] c_HALT = 3'd4;

    localparam int         c_KM_W    = (KILLS_PER_LEVEL > 1) ? $clog2(KILLS_PER_LEVEL) : 1;
    localparam logic [8:0] c_BASE    = 9'(BASE_INTERVAL);
    localparam logic [8:0] c_STEP    = 9'(INTERVAL_STEP);
    localparam logic [8:0] c_MIN     = 9'(MIN_INTERVAL);
    localparam logic [7:0] c_ACK_TO  = 8'(ACK_TIMEOUT);
    localparam logic [9:0] c_XMAX    = 10'(X_MAX);
    localparam logic [9:0] c_XWRAP   = 10'(X_MAX + 1);
    localparam logic [3:0] c_MAXLVL  = 4'(MAX_LEVEL);
    localparam logic [c_KM_W-1:0] c_KM_LAST = c_KM_W'(KILLS_PER_LEVEL - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_vs_meta;
    logic              r_vs_sync;
    logic              r_vs_prev;
    logic              r_bullet_prev;
    logic [7:0]        r_frame_cnt;
    logic [7:0]        r_to_cnt;
    logic [c_KM_W-1:0] r_kill_mod;

    logic       w_frame_tick;
    logic       w_kill_pulse;
    logic [7:0] w_frame_next;
    logic [7:0] w_to_next;
    logic [8:0] w_dec;
    logic [8:0] w_diff;
    logic [7:0] w_interval;
    logic       w_interval_hit;
    logic       w_timeout_hit;
    logic       w_ack_match;
    logic       w_pick_type;
    logic [9:0] w_raw;
    logic [9:0] w_pick_x;
    logic       w_unused_rand;

    assign w_frame_tick = r_vs_sync & ~r_vs_prev;
    assign w_kill_pulse = crash_enemy_bullet_i & ~r_bullet_prev;

    // Signed compare so a large level never wraps the interval to a big value.
    assign w_dec      = {5'd0, level_o} * c_STEP;
    assign w_diff     = c_BASE - w_dec;
    assign w_interval = ($signed(w_diff) < $signed(c_MIN)) ? c_MIN[7:0] : w_diff[7:0];

    assign w_frame_next   = r_frame_cnt + {7'd0, w_frame_tick};
    assign w_to_next      = r_to_cnt + {7'd0, w_frame_tick};
    assign w_interval_hit = (w_frame_next >= w_interval);
    assign w_timeout_hit  = (w_to_next >= c_ACK_TO);
    assign w_ack_match    = spawn_type_o ? spawn_ack2_i : spawn_ack1_i;

    assign w_pick_type   = (rand_i[RAND_WIDTH-1 -: 4] < level_o);
    assign w_raw         = rand_i[9:0];
    assign w_pick_x      = (w_raw <= c_XMAX) ? w_raw : (w_raw - c_XWRAP);
    assign w_unused_rand = ^rand_i[RAND_WIDTH-5:10];

    always_ff @(posedge clk_run) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == c_HALT) begin
            w_next_state = c_HALT;
        end else if (crash_me_enemy_i) begin
            w_next_state = c_HALT;
        end else if (!en_i) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  w_next_state = c_WAIT;
                c_WAIT:  if (w_interval_hit) w_next_state = c_PICK;
                c_PICK:  w_next_state = c_REQ;
                // Ack is checked first so it wins over a same-cycle timeout.
                c_REQ:   if (w_ack_match || w_timeout_hit) w_next_state = c_WAIT;
                default: w_next_state = c_IDLE;
            endcase
        end
    end

    always_comb begin
        spawn_req_o = (r_state == c_REQ);
        halted_o    = (r_state == c_HALT);
    end

    always_ff @(posedge clk_run) begin
        if (rst) begin
            r_vs_meta     <= 1'b0;
            r_vs_sync     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_bullet_prev <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_to_cnt      <= 8'd0;
            r_kill_mod    <= '0;
            spawn_type_o  <= 1'b0;
            spawn_x_o     <= 10'd0;
            level_o       <= 4'd0;
            kill_cnt_o    <= 16'd0;
        end else begin
            r_vs_meta     <= v_sync_i;
            r_vs_sync     <= r_vs_meta;
            r_vs_prev     <= r_vs_sync;
            r_bullet_prev <= crash_enemy_bullet_i;

            r_frame_cnt <= (r_state == c_WAIT && w_next_state == c_WAIT) ? w_frame_next : 8'd0;
            r_to_cnt    <= (r_state == c_REQ && w_next_state == c_REQ) ? w_to_next : 8'd0;

            if (r_state == c_PICK) begin
                spawn_type_o <= w_pick_type;
                spawn_x_o    <= w_pick_x;
            end

            if (w_kill_pulse && en_i && r_state != c_HALT) begin
                if (kill_cnt_o != 16'hFFFF) begin
                    kill_cnt_o <= kill_cnt_o + 16'd1;
                end
                if (r_kill_mod == c_KM_LAST) begin
                    r_kill_mod <= '0;
                    if (level_o != c_MAXLVL) begin
                        level_o <= level_o + 4'd1;
                    end
                end else begin
                    r_kill_mod <= r_kill_mod + c_KM_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_spawn_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_enemy_spawn_sched
// Brief   : Directed, table-driven bench for enemy_spawn_sched.
// Revision: 1.0 - initial release
// ============================================================================
module tb_enemy_spawn_sched;

    logic        clk_run = 1'b0;
    logic        rst;
    logic        en_i;
    logic [15:0] rand_i;
    logic        v_sync_i;
    logic        crash_enemy_bullet_i;
    logic        crash_me_enemy_i;
    logic        spawn_ack1_i;
    logic        spawn_ack2_i;
    logic        spawn_req_o;
    logic        spawn_type_o;
    logic [9:0]  spawn_x_o;
    logic [3:0]  level_o;
    logic [15:0] kill_cnt_o;
    logic        halted_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_run = ~clk_run;

    enemy_spawn_sched dut (
        .clk_run              (clk_run),
        .rst                  (rst),
        .en_i                 (en_i),
        .rand_i               (rand_i),
        .v_sync_i             (v_sync_i),
        .crash_enemy_bullet_i (crash_enemy_bullet_i),
        .crash_me_enemy_i     (crash_me_enemy_i),
        .spawn_ack1_i         (spawn_ack1_i),
        .spawn_ack2_i         (spawn_ack2_i),
        .spawn_req_o          (spawn_req_o),
        .spawn_type_o         (spawn_type_o),
        .spawn_x_o            (spawn_x_o),
        .level_o              (level_o),
        .kill_cnt_o           (kill_cnt_o),
        .halted_o             (halted_o)
    );

    typedef struct {
        int          kills;
        logic [15:0] rnd;
        int          lvl;
        int          kcnt;
        int          ivl;
        int          typ;
        int          x;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc();
        @(posedge clk_run);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    task automatic frame();
        v_sync_i = 1'b1;
        cyc(); cyc();
        v_sync_i = 1'b0;
        cyc(); cyc();
    endtask

    task automatic kill(input int n);
        for (int k = 0; k < n; k++) begin
            crash_enemy_bullet_i = 1'b1;
            repeat (3) cyc();
            crash_enemy_bullet_i = 1'b0;
            repeat (2) cyc();
        end
    endtask

    task automatic wait_req(output int frames);
        frames = 0;
        while (!spawn_req_o && frames < 400) begin
            frame();
            frames++;
        end
    endtask

    task automatic ack(input logic typ);
        if (typ) spawn_ack2_i = 1'b1;
        else     spawn_ack1_i = 1'b1;
        cyc();
        spawn_ack1_i = 1'b0;
        spawn_ack2_i = 1'b0;
    endtask

    initial begin
        int f;

        vecs[0] = '{0,   16'h024E, 0,  0,   60, 0, 590};
        vecs[1] = '{10,  16'h0000, 1,  10,  56, 1, 0};
        vecs[2] = '{10,  16'h23FF, 2,  20,  52, 0, 432};
        vecs[3] = '{100, 16'hB24F, 12, 120, 15, 1, 0};
        vecs[4] = '{40,  16'hE3E8, 15, 160, 15, 1, 409};
        vecs[5] = '{0,   16'hF100, 15, 160, 15, 0, 256};

        en_i = 1'b0; rand_i = 16'h0; v_sync_i = 1'b0;
        crash_enemy_bullet_i = 1'b0; crash_me_enemy_i = 1'b0;
        spawn_ack1_i = 1'b0; spawn_ack2_i = 1'b0;
        do_reset();

        check("rst_req",    int'(spawn_req_o),  0);
        check("rst_type",   int'(spawn_type_o), 0);
        check("rst_x",      int'(spawn_x_o),    0);
        check("rst_level",  int'(level_o),      0);
        check("rst_kills",  int'(kill_cnt_o),   0);
        check("rst_halted", int'(halted_o),     0);

        // First spawn: exact latency from the 60th vsync edge, x wraps 1000 -> 409
        en_i   = 1'b1;
        rand_i = 16'h03E8;
        cyc(); cyc();
        repeat (59) frame();
        check("t1_no_req_59", int'(spawn_req_o), 0);
        v_sync_i = 1'b1;
        cyc(); cyc();
        v_sync_i = 1'b0;
        cyc();
        check("t1_req_early", int'(spawn_req_o), 0);
        cyc();
        check("t1_req_rise", int'(spawn_req_o), 1);
        check("t1_type",     int'(spawn_type_o), 0);
        check("t2_x_1000",   int'(spawn_x_o),   409);
        ack(1'b1);
        check("t4_wrong_ack_held", int'(spawn_req_o), 1);
        ack(1'b0);
        check("t1_ack_drop", int'(spawn_req_o), 0);

        foreach (vecs[i]) begin
            rand_i = vecs[i].rnd;
            kill(vecs[i].kills);
            check($sformatf("v%0d_level", i), int'(level_o),    vecs[i].lvl);
            check($sformatf("v%0d_kills", i), int'(kill_cnt_o), vecs[i].kcnt);
            wait_req(f);
            check($sformatf("v%0d_interval", i), f, vecs[i].ivl);
            check($sformatf("v%0d_type", i), int'(spawn_type_o), vecs[i].typ);
            check($sformatf("v%0d_x", i),    int'(spawn_x_o),    vecs[i].x);
            ack(logic'(vecs[i].typ));
            check($sformatf("v%0d_ack_drop", i), int'(spawn_req_o), 0);
        end

        // Timeout: enemy1 request withheld for 8 frames
        wait_req(f);
        check("to_interval", f, 15);
        ack(1'b1);
        check("to_wrong_ack_held", int'(spawn_req_o), 1);
        repeat (7) frame();
        check("to_held_7", int'(spawn_req_o), 1);
        frame();
        check("to_drop_8", int'(spawn_req_o), 0);
        wait_req(f);
        check("to_back_in_wait", f, 15);

        // Pause mid-request
        en_i = 1'b0;
        cyc();
        check("pause_req_clear", int'(spawn_req_o), 0);
        kill(1);
        check("pause_kills_held", int'(kill_cnt_o), 160);
        check("pause_level_held", int'(level_o),    15);
        en_i = 1'b1;
        wait_req(f);
        check("resume_interval", f, 15);

        // Crash with a same-cycle matching ack
        crash_me_enemy_i = 1'b1;
        spawn_ack1_i     = 1'b1;
        cyc();
        crash_me_enemy_i = 1'b0;
        spawn_ack1_i     = 1'b0;
        check("crash_halted", int'(halted_o),    1);
        check("crash_req",    int'(spawn_req_o), 0);
        repeat (20) frame();
        check("halt_no_req",   int'(spawn_req_o), 0);
        check("halt_stays",    int'(halted_o),    1);
        kill(1);
        check("halt_no_kills", int'(kill_cnt_o),  160);
        do_reset();
        check("rst2_halted", int'(halted_o),   0);
        check("rst2_level",  int'(level_o),    0);
        check("rst2_kills",  int'(kill_cnt_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
